// File: rtl/cla_pkg.sv
// Shared constants for the registered carry-lookahead adder.
package cla_pkg;
    localparam int CLA_GROUP = 4;
    localparam int CLA_WIDTH = 4;
endpackage

// File: rtl/cla4_group.sv
// One 4-bit lookahead group: parallel carries from g/p and c0, plus group generate/propagate.
module cla4_group
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a_i,
    input  logic [CLA_GROUP-1:0] b_i,
    input  logic                 c0_i,
    output logic [CLA_GROUP-1:0] sum_o,
    output logic                 gg_o,
    output logic                 gp_o,
    output logic                 c4_o
);
    logic [3:0] g, p, c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum of products so nothing ripples inside the group.
    assign c[0] = c0_i;
    assign c[1] = g[0] | (p[0] & c0_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
    assign c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c0_i);

    assign gg_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp_o  = &p;
    assign sum_o = p ^ c;
endmodule

// File: rtl/cla_final_circuit.sv
// Two-stage pipelined adder: input registers, lookahead groups chained by GG/GP, output registers.
module cla_final_circuit
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int NG = WIDTH / CLA_GROUP;

    if (WIDTH <= 0 || (WIDTH % CLA_GROUP) != 0) begin : g_bad_width
        $error("cla_final_circuit: WIDTH must be a positive multiple of 4");
    end

    logic [WIDTH-1:0] a_q, b_q, s_q, sum_d;
    logic             cin_q, cout_q, cout_d;
    logic [NG:0]      gc;
    logic [NG-1:0]    gg, gp, c4_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            cin_q  <= cin;
            s_q    <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign gc[0] = cin_q;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4_group u_grp (
            .a_i   (a_q[CLA_GROUP*k +: CLA_GROUP]),
            .b_i   (b_q[CLA_GROUP*k +: CLA_GROUP]),
            .c0_i  (gc[k]),
            .sum_o (sum_d[CLA_GROUP*k +: CLA_GROUP]),
            .gg_o  (gg[k]),
            .gp_o  (gp[k]),
            .c4_o  (c4_unused[k])
        );
        // Second lookahead level: group carries skip across via GG/GP.
        assign gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end

    assign cout_d = gc[NG];
    assign s      = s_q;
    assign cout   = cout_q;
endmodule

// File: tb/tb_cla_final_circuit.sv
// Bench for the pipelined adder at WIDTH=4 (directed + exhaustive) and WIDTH=16 (random).
module tb_cla_final_circuit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic        cin4 = 1'b0, cout4;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 1'b0, cout16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_final_circuit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .s(s4), .cout(cout4)
    );
    cla_final_circuit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(cout16)
    );

    // Reference: full-precision integer sum, delayed two edges, zeroed by reset.
    int unsigned m4_in, m4_out, m16_in, m16_out;
    always @(posedge clk) begin
        if (rst) begin
            m4_in <= 0; m4_out <= 0; m16_in <= 0; m16_out <= 0;
        end else begin
            m4_in   <= int'(a4) + int'(b4) + int'(cin4);
            m4_out  <= m4_in;
            m16_in  <= int'(a16) + int'(b16) + int'(cin16);
            m16_out <= m16_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and compare both instances against the model.
    task automatic tick();
        @(negedge clk);
        chk("model4", {27'd0, cout4, s4}, m4_out);
        chk("model16", {15'd0, cout16, s16}, m16_out);
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    endtask

    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vc [4];
    logic [4:0] ve [4];

    initial begin
        va = '{4'b0000, 4'b1001, 4'b1010, 4'b1010};
        vb = '{4'b0000, 4'b1101, 4'b0101, 4'b0101};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1};
        ve = '{5'b0_0000, 5'b1_0110, 5'b0_1111, 5'b1_0000};

        // Reset held two edges with all-ones operands, then one edge past release.
        drive(4'b1111, 4'b1111, 1'b1);
        @(negedge clk);
        chk("rst_e1", {27'd0, cout4, s4}, 32'd0);
        @(negedge clk);
        chk("rst_e2", {27'd0, cout4, s4}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_rel", {27'd0, cout4, s4}, 32'd0);

        // Back-to-back directed operands; each result lands two edges later.
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) chk("b2b", {27'd0, cout4, s4}, {27'd0, ve[i-2]});
            if (i < 4) drive(va[i], vb[i], vc[i]);
            tick();
        end

        // Reset for one edge with two operand sets in flight.
        drive(4'b1001, 4'b1101, 1'b0);
        tick();
        drive(4'b1111, 4'b1111, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst0", {27'd0, cout4, s4}, 32'd0);
        drive(4'b1010, 4'b0101, 1'b1);
        tick();
        chk("mid_rst1", {27'd0, cout4, s4}, 32'd0);
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        chk("mid_rst2", {27'd0, cout4, s4}, 32'd16);

        // Exhaustive 4-bit space alongside random 16-bit operands.
        for (int v = 0; v < 512; v++) begin
            drive(v[3:0], v[7:4], v[8]);
            tick();
        end
        drive(4'b0000, 4'b0000, 1'b0);
        tick();
        tick();

        // Directed 16-bit full-propagate carry across all groups.
        a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
        tick();
        tick();
        chk("prop16", {15'd0, cout16, s16}, 32'h1_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_final_circuit.md
# cla_final_circuit

Registered 4-bit carry-lookahead adder: adds `a`, `b` and carry-in `cin`, producing sum `s` and carry-out `cout`. It sits in the datapath as a drop-in pipelined adder. Operands are captured in an input register stage, added by a two-level lookahead network, and the result is captured in an output register stage. The block is width-parameterised in 4-bit lookahead groups and defaults to 4 bits.

## Interface
- `WIDTH`, 4, operand/sum width; must be a positive multiple of 4.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  reset; synchronous and active-high.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in.
- `s`  output  WIDTH  registered sum, equal to (a + b + cin) mod 2^WIDTH.
- `cout`  output  1  registered carry-out, equal to bit WIDTH of a + b + cin.

## Operation
- **Stage 1.** On each rising `clk` with `rst`=0, `a`, `b` and `cin` are captured into input registers `a_q`, `b_q` and `cin_q`.
- **Per-bit logic.** Generate g[i] = a_q[i] & b_q[i]; propagate p[i] = a_q[i] ^ b_q[i].
- **Group carries (4-bit group).** Computed in parallel from g, p and the group carry-in c0; no rippling inside a group:
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·c3 expanded fully
- **Group outputs.** Each group produces GG = g3 | p3g2 | p3p2g1 | p3p2p1g0 and GP = p3p2p1p0.
- **Between groups.** The carry into group k+1 is GG_k | GP_k·c_k. Group 0 carry-in is `cin_q`.
- **Sum.** s[i] = p[i] ^ c[i]. The carry-out is the carry out of the top group.
- **Stage 2.** On the next rising edge with `rst`=0, the combinational sum and carry-out are captured into the `s` and `cout` registers.
- **Arithmetic.** Unsigned. Overflow appears only on `cout`; the sum wraps modulo 2^WIDTH.
- **Reset.** When `rst`=1 at a rising edge, `a_q`, `b_q`, `cin_q`, `s` and `cout` all clear to 0 on that edge. `rst` has priority over input capture.
- **Reset values.** `s`=0, `cout`=0.
- **Reset mid-operation.** Any operands in flight are discarded. After `rst` is released, `s`/`cout` stay 0 until the first post-reset operand reaches the output, two edges later.

## Timing
- **Latency.** 2 rising edges. Operands present at edge N appear on `s`/`cout` after edge N+1.
- **Throughput.** One new operand set per cycle; fully pipelined, no stalls, no handshake.
- **Setup.** Inputs are sampled only at rising edges. Changes between edges have no effect until the next edge.
- **Outputs.** `s`/`cout` change only on rising edges and are glitch-free.
- **Critical path.** Input register → per-bit g/p → group lookahead → inter-group carry → sum XOR → output register.

## Structure
- **Package `cla_pkg`.** Holds `CLA_GROUP = 4` and the default width constant `CLA_WIDTH = 4`.
- **Sub-module `cla4_group`.** Purely combinational: 4-bit a, b, c0 in; 4-bit sum, GG, GP, c4 out. It is instantiated WIDTH/4 times via generate.
- **Top level.** The registers and the inter-group carry chain live in the top module.
- **Elaboration check.** An elaboration-time check rejects WIDTH not divisible by 4.

## Test plan
- **Reset.** Hold `rst`=1 for 2 edges with a=1111, b=1111, cin=1 → s=0000, cout=0 throughout reset and for one edge after release.
- **Carry-out case.** a=1001, b=1101, cin=0 → s=0110, cout=1 after 2 edges.
- **No-carry, all-propagate case.** a=1010, b=0101, cin=0 → s=1111, cout=0. Repeat with cin=1 → s=0000, cout=1, testing full carry propagation.
- **Back-to-back pipelining.** Change operands every cycle: 0000+0000, then 1001+1101, then 1010+0101 → outputs 0/0000, 1/0110, 0/1111 on consecutive cycles, each 2 edges after its input.
- **Mid-stream reset.** Assert `rst` for one edge while two operand sets are in flight → both are discarded and outputs read 0 until fresh operands arrive.
- **Exhaustive check.** All 512 combinations of a, b and cin at WIDTH=4 against a+b+cin. Repeat randomised at WIDTH=16 to check the inter-group carry.
